mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares a single synchronous memory port between the processor's instruction-fetch path and its load/store data path.
- Grants one requester at a time with round-robin fairness and holds exactly one outstanding memory transaction.
- Returns read data with a one-cycle valid pulse and aborts transactions the memory never acknowledges.
- Sits between the processor core and the memory/bus model.

Parameters:
- AW, 32, address width of all address ports.
- DW, 32, data width of all data ports.
- TIMEOUT, 15, wait cycles without mem_ack before the transaction is aborted; must be ≥1.
- ERR_WORD, 32'h0000_0013, data returned on an aborted read (NOP encoding).

Ports:
- CLK  input  1  clock, rising edge.
- RES  input  1  reset; asynchronous assert, active-low, synchronous deassert outside this block.
- instr_req  input  1  fetch request; held high with stable instr_adr until instr_valid.
- instr_adr  input  AW  fetch address.
- instr_valid  output  1  one-cycle pulse: instr_read valid, fetch complete.
- instr_read  output  DW  fetched word, held until next fetch completes.
- data_req  input  1  data request; held high with stable address, we, be and wdata until data_valid.
- data_we  input  1  1 = store, 0 = load.
- data_adr  input  AW  data address.
- data_be  input  4  byte enables for stores.
- data_wdata  input  DW  store data.
- data_valid  output  1  one-cycle pulse: data access complete, data_rdata valid for loads.
- data_rdata  output  DW  load data, held until next data access completes.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write.
- mem_adr  output  AW  memory address.
- mem_be  output  4  memory byte enables.
- mem_wdata  output  DW  memory write data.
- mem_ack  input  1  memory completion, one cycle; mem_rdata valid in the same cycle.
- mem_rdata  input  DW  memory read data.
- err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (RES=0, asynchronous):
  - state=IDLE, last_grant=DATA (so instruction fetch wins first).
  - All outputs 0; instr_read and data_rdata cleared to 0; wait counter 0.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Samples requests.
  - Only one requester high: grant it.
  - Both high: grant the one not in last_grant; update last_grant to the winner.
  - No request: stay in IDLE.
- On grant (edge leaving IDLE):
  - Register address, we, be, wdata into the mem_* outputs; mem_req=1 from the next cycle.
  - Instruction grants always have mem_we=0 and mem_be=4'hF.
  - Clear the wait counter.
  - Latency from request to mem_req is 1 cycle.
- BUSY_x:
  - mem_* outputs are held stable.
  - mem_ack=1: latch mem_rdata into the owner's rdata register (loads and fetches only; stores leave data_rdata unchanged), drop mem_req, go to DONE. Owner's valid=1 in DONE.
  - mem_ack=0: increment the counter. When the counter reaches TIMEOUT, drop mem_req, load ERR_WORD into the owner's rdata (reads only), pulse err for one cycle aligned with valid, go to DONE.
- DONE:
  - Exactly one valid pulse for the owner.
  - Requests are ignored this cycle so the requester can deassert; next state is IDLE.
- Back-to-back: a requester keeping req high after valid issues a new transaction.
  - Minimum spacing is 4 cycles per transaction with a 1-cycle memory: IDLE, BUSY, DONE, IDLE.
- mem_ack while in IDLE or DONE is ignored.
- Requester deasserting req while in BUSY is illegal. The transaction still completes and valid is still pulsed.
- Reset mid-transaction:
  - Immediate return to IDLE, mem_req=0, no valid pulse.
  - The memory side must tolerate the abandoned request.
- instr_valid and data_valid are never high in the same cycle. err is never high outside DONE.

Test Plan:
- Single fetch: instr_req=1, instr_adr=0x100, memory acks 2 cycles after mem_req with 0x00500093 -> mem_adr=0x100, mem_we=0; instr_valid pulses once with instr_read=0x00500093; 5 cycles from req to valid.
- Store: data_req=1, data_we=1, data_adr=0x2000, data_be=4'b0011, data_wdata=0xDEADBEEF, immediate ack -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; data_valid pulses; data_rdata unchanged.
- Contention: both requests held continuously from reset, 1-cycle memory -> grants alternate I,D,I,D; valid pulses every 4 cycles; first grant is instruction.
- Timeout: fetch granted, mem_ack never asserted -> mem_req drops after 15 wait cycles; instr_valid and err pulse together; instr_read=0x00000013; next request is served normally.
- Reset mid-access: assert RES=0 while in BUSY_D -> all outputs 0 asynchronously with no valid pulse; after release, a fresh fetch completes normally.
- Stray ack: mem_ack pulsed while in IDLE and while in DONE -> no state change, no extra valid pulse, rdata registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// slave = arbiter view, master = core + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          instr_req;
  logic [AW-1:0] instr_adr;
  logic          instr_valid;
  logic [DW-1:0] instr_read;

  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_adr;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata;
  logic          data_valid;
  logic [DW-1:0] data_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          err;

  modport slave (
    input  instr_req, instr_adr,
    output instr_valid, instr_read,
    input  data_req, data_we, data_adr, data_be, data_wdata,
    output data_valid, data_rdata,
    output mem_req, mem_we, mem_adr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output err
  );

  modport master (
    output instr_req, instr_adr,
    input  instr_valid, instr_read,
    output data_req, data_we, data_adr, data_be, data_wdata,
    input  data_valid, data_rdata,
    input  mem_req, mem_we, mem_adr, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one outstanding transaction, with a wait-cycle timeout that aborts unacknowledged accesses.
module mem_port_arbiter #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    TIMEOUT  = 15,
  parameter logic [DW-1:0]  ERR_WORD = DW'(32'h0000_0013)
) (
  input  logic               CLK,
  input  logic               RES,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e        state_q;
  owner_e        last_q;
  logic [CW-1:0] cnt_q;

  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_adr_q;
  logic [3:0]    mem_be_q;
  logic [DW-1:0] mem_wdata_q;
  logic          instr_valid_q;
  logic          data_valid_q;
  logic          err_q;
  logic [DW-1:0] instr_read_q;
  logic [DW-1:0] data_rdata_q;

  logic          grant_i_d;
  logic [CW:0]   cnt_inc_d;
  logic          timeout_d;
  logic [DW-1:0] rdata_d;

  always_comb begin
    grant_i_d = bus.instr_req && (!bus.data_req || last_q == OWN_D);
    cnt_inc_d = {1'b0, cnt_q} + 1'b1;
    timeout_d = (cnt_inc_d == (CW+1)'(TIMEOUT));
    rdata_d   = bus.mem_ack ? bus.mem_rdata : ERR_WORD;
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q       <= IDLE;
      last_q        <= OWN_D;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_adr_q     <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      instr_read_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      // valid/err are set on the edge into DONE and cleared on every other edge,
      // so each completion yields exactly one pulse aligned with DONE
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.instr_req || bus.data_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (grant_i_d) begin
              state_q     <= BUSY_I;
              last_q      <= OWN_I;
              mem_we_q    <= 1'b0;
              mem_adr_q   <= bus.instr_adr;
              mem_be_q    <= 4'hF;
              mem_wdata_q <= '0;
            end else begin
              state_q     <= BUSY_D;
              last_q      <= OWN_D;
              mem_we_q    <= bus.data_we;
              mem_adr_q   <= bus.data_adr;
              mem_be_q    <= bus.data_be;
              mem_wdata_q <= bus.data_wdata;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ack || timeout_d) begin
            mem_req_q <= 1'b0;
            err_q     <= !bus.mem_ack;
            state_q   <= DONE;
            if (state_q == BUSY_I) begin
              instr_valid_q <= 1'b1;
              instr_read_q  <= rdata_d;
            end else begin
              data_valid_q <= 1'b1;
              if (!mem_we_q) data_rdata_q <= rdata_d;
            end
          end else begin
            cnt_q <= cnt_inc_d[CW-1:0];
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req     = mem_req_q;
    bus.mem_we      = mem_we_q;
    bus.mem_adr     = mem_adr_q;
    bus.mem_be      = mem_be_q;
    bus.mem_wdata   = mem_wdata_q;
    bus.instr_valid = instr_valid_q;
    bus.instr_read  = instr_read_q;
    bus.data_valid  = data_valid_q;
    bus.data_rdata  = data_rdata_q;
    bus.err         = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// contention, stray-ack and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned TIMEOUT  = 15;
  localparam logic [31:0] ERR_WORD = 32'h0000_0013;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)
  ) dut (
    .CLK(clk),
    .RES(res),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iadr;
    logic        dreq;
    logic        dwe;
    logic [31:0] dadr;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    int unsigned delay;     // BUSY cycles before the ack cycle
    logic        no_ack;
    logic [31:0] rdata;
    logic        stray;     // keep mem_ack high through DONE
    logic        own_i;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_adr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_iread;
    logic [31:0] exp_drd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic idle_inputs();
    bus.instr_req  = 1'b0;
    bus.instr_adr  = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_adr   = '0;
    bus.data_be    = '0;
    bus.data_wdata = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Called at a negedge; returns at the negedge after the cycle following DONE.
  task automatic run_txn(input vec_t v, input string tag);
    int unsigned waits;
    bus.instr_req  = v.ireq;
    bus.instr_adr  = v.iadr;
    bus.data_req   = v.dreq;
    bus.data_we    = v.dwe;
    bus.data_adr   = v.dadr;
    bus.data_be    = v.dbe;
    bus.data_wdata = v.dwdata;
    @(negedge clk);
    check({tag, "/mem_req"}, 32'(bus.mem_req), 32'd1);
    check({tag, "/mem_we"},  32'(bus.mem_we), 32'(v.exp_we));
    check({tag, "/mem_be"},  32'(bus.mem_be), 32'(v.exp_be));
    check({tag, "/mem_adr"}, bus.mem_adr, v.exp_adr);
    if (v.exp_we) check({tag, "/mem_wdata"}, bus.mem_wdata, v.exp_wdata);
    check({tag, "/early_valid"}, 32'({bus.instr_valid, bus.data_valid, bus.err}), 32'd0);
    waits = v.no_ack ? TIMEOUT - 1 : v.delay;
    for (int unsigned i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, "/busy_hold"}, 32'({bus.mem_req, bus.instr_valid, bus.data_valid, bus.err}), 32'b1000);
    end
    if (!v.no_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = v.rdata;
    end
    @(negedge clk);
    check({tag, "/valid"},  32'({bus.instr_valid, bus.data_valid}), v.own_i ? 32'b10 : 32'b01);
    check({tag, "/err"},    32'(bus.err), 32'(v.exp_err));
    check({tag, "/mem_req_drop"}, 32'(bus.mem_req), 32'd0);
    check({tag, "/instr_read"}, bus.instr_read, v.exp_iread);
    check({tag, "/data_rdata"}, bus.data_rdata, v.exp_drd);
    bus.instr_req = 1'b0;
    bus.data_req  = 1'b0;
    bus.mem_ack   = v.stray;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check({tag, "/one_pulse"}, 32'({bus.instr_valid, bus.data_valid, bus.err, bus.mem_req}), 32'd0);
    check({tag, "/instr_read_kept"}, bus.instr_read, v.exp_iread);
    check({tag, "/data_rdata_kept"}, bus.data_rdata, v.exp_drd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_v;
    logic       seen;
    vec_t       post;

    //            ireq iadr          dreq dwe dadr          dbe    dwdata        dly noack rdata         stray own_i we be    adr           wdata         iread         drd           err
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,       4'h0,  32'h0,        2, 1'b0, 32'h0050_0093, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h0050_0093, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_2000, 4'h3, 32'hDEAD_BEEF, 0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_2004, 4'hF, 32'h0,        1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_2004, 32'h0,        32'h0050_0093, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_2008, 4'hF, 32'h0,        0, 1'b0, 32'h00A0_0113, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0,        32'h00A0_0113, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0108, 1'b1, 1'b1, 32'h0000_200C, 4'hC, 32'h0102_0304, 0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 4'hC, 32'h0000_200C, 32'h0102_0304, 32'h00A0_0113, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_010C, 1'b0, 1'b0, 32'h0,       4'h0,  32'h0,        0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_010C, 32'h0,        32'h0000_0013, 32'hCAFE_F00D, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0110, 1'b0, 1'b0, 32'h0,       4'h0,  32'h0,        0, 1'b0, 32'h0000_0517, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0110, 32'h0,        32'h0000_0517, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_3000, 4'hF, 32'h1111_2222, 0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 4'hF, 32'h0000_3000, 32'h1111_2222, 32'h0000_0517, 32'hCAFE_F00D, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3004, 4'hF, 32'h0,        0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_3004, 32'h0,        32'h0000_0517, 32'h0000_0013, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3008, 4'hF, 32'h0,        3, 1'b0, 32'h0BAD_C0DE, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_3008, 32'h0,        32'h0000_0517, 32'h0BAD_C0DE, 1'b0};

    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset/outputs", 32'({bus.mem_req, bus.mem_we, bus.mem_be, bus.instr_valid, bus.data_valid, bus.err}), 32'd0);
    check("reset/mem_adr", bus.mem_adr, 32'h0);
    check("reset/instr_read", bus.instr_read, 32'h0);
    check("reset/data_rdata", bus.data_rdata, 32'h0);
    res = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stray ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("stray_idle/quiet", 32'({bus.instr_valid, bus.data_valid, bus.err, bus.mem_req}), 32'd0);
    check("stray_idle/instr_read", bus.instr_read, 32'h0000_0517);
    check("stray_idle/data_rdata", bus.data_rdata, 32'h0BAD_C0DE);

    // Contention from reset, memory acking one cycle after it first sees mem_req
    res = 1'b0;
    bus.instr_req = 1'b1;
    bus.instr_adr = 32'h0000_0200;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_adr  = 32'h0000_4000;
    bus.data_be   = 4'hF;
    @(negedge clk);
    res  = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_v = (k == 3 || k == 11) ? 2'b10 : (k == 7 || k == 15) ? 2'b01 : 2'b00;
      check($sformatf("rr/valid_k%0d", k), 32'({bus.instr_valid, bus.data_valid}), 32'(exp_v));
      if (k == 1)  check("rr/first_grant_adr", bus.mem_adr, 32'h0000_0200);
      if (k == 5)  check("rr/second_grant_adr", bus.mem_adr, 32'h0000_4000);
      if (k == 9)  check("rr/third_grant_adr", bus.mem_adr, 32'h0000_0200);
      if (k == 3)  check("rr/instr_read", bus.instr_read, 32'h0000_0201);
      if (k == 7)  check("rr/data_rdata", bus.data_rdata, 32'h0000_4001);
      bus.mem_ack   = bus.mem_req && seen && !bus.mem_ack;
      bus.mem_rdata = bus.mem_adr + 32'd1;
      seen          = bus.mem_req;
    end
    idle_inputs();
    @(negedge clk);

    // Reset while a load is outstanding
    bus.data_req = 1'b1;
    bus.data_we  = 1'b0;
    bus.data_adr = 32'h0000_5000;
    bus.data_be  = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_mid/busy", 32'(bus.mem_req), 32'd1);
    #1 res = 1'b0;
    #1;
    check("rst_mid/mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid/mem_adr", bus.mem_adr, 32'h0);
    check("rst_mid/mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mid/flags", 32'({bus.instr_valid, bus.data_valid, bus.err, bus.mem_we}), 32'd0);
    check("rst_mid/instr_read", bus.instr_read, 32'h0);
    check("rst_mid/data_rdata", bus.data_rdata, 32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_mid/no_valid", 32'({bus.instr_valid, bus.data_valid}), 32'd0);
    res = 1'b1;
    @(negedge clk);
    post = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b0, 32'h00C0_0193, 1'b0,
             1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h00C0_0193, 32'h0, 1'b0};
    run_txn(post, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
